// File: rtl/hart_pkg.sv
// Shared types and constants for the heartbeat stress classifier:
// FSM states, class thresholds and the average-to-level mapping.
package hart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    TRACK = 2'd3
  } hart_state_e;

  localparam logic [15:0] THR_1 = 16'd1000;
  localparam logic [15:0] THR_2 = 16'd857;
  localparam logic [15:0] THR_3 = 16'd750;
  localparam logic [15:0] THR_4 = 16'd667;
  localparam logic [15:0] THR_5 = 16'd600;
  localparam logic [15:0] THR_6 = 16'd500;

  localparam logic [2:0] STATUS_NONE = 3'd0;
  localparam int         AVG_DEPTH   = 4;

  // Longer average interval means a slower heart rate, hence a lower stress level.
  function automatic logic [2:0] classify(input logic [15:0] avg);
    logic [2:0] lvl;
    if (avg >= THR_1) begin
      lvl = 3'd1;
    end else if (avg >= THR_2) begin
      lvl = 3'd2;
    end else if (avg >= THR_3) begin
      lvl = 3'd3;
    end else if (avg >= THR_4) begin
      lvl = 3'd4;
    end else if (avg >= THR_5) begin
      lvl = 3'd5;
    end else if (avg >= THR_6) begin
      lvl = 3'd6;
    end else begin
      lvl = 3'd7;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// registered one-clock rising-edge pulse (pulse rises on the 3rd clock edge).
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchronizer chain and edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r  <= 1'b0;
      s2_r  <= 1'b0;
      s3_r  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1_r  <= din;
      s2_r  <= s1_r;
      s3_r  <= s2_r;
      pulse <= s2_r & ~s3_r;
    end
  end

endmodule

// File: rtl/hart_stress_classifier.sv
// Measures heartbeat intervals in timebase ticks, averages the last four valid
// intervals and maps the average to a 3-bit stress level; detects signal loss.
module hart_stress_classifier
  import hart_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int PERIOD_W   = 12,
  parameter int MIN_PERIOD = 250,
  parameter int TIMEOUT    = 3000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                beat_in,
  output logic [2:0]          status,
  output logic                status_valid,
  output logic                status_upd,
  output logic [PERIOD_W-1:0] avg_period,
  output logic                lost
);

  localparam int                  DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [PERIOD_W-1:0] MIN_C     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] TO_LAST_C = PERIOD_W'(TIMEOUT - 1);
  localparam int                  SUM_W     = PERIOD_W + 2;

  logic                beat_evt_s;
  logic                tick_s;
  logic                timeout_s;
  logic                push_s;
  logic                clr_s;
  logic                cnt_clr_s;
  logic                track_push_s;
  hart_state_e         state_r;
  hart_state_e         state_n_s;
  logic [2:0]          fill_r;
  logic [DIV_W-1:0]    presc_r;
  logic [PERIOD_W-1:0] cnt_r;
  logic [PERIOD_W-1:0] buf_r [AVG_DEPTH];
  logic [SUM_W-1:0]    sum_r;
  logic [PERIOD_W-1:0] avg_s;
  logic                upd_pend_r;
  logic                trk_pend_r;

  pulse_sync_edge u_beat_sync (
    .clk   (clk),
    .rst   (reset),
    .din   (beat_in),
    .pulse (beat_evt_s)
  );

  assign tick_s       = (presc_r == DIV_LAST);
  // The tick that would take cnt to TIMEOUT is the timeout event itself.
  assign timeout_s    = tick_s && (cnt_r == TO_LAST_C) && (state_r != IDLE);
  assign track_push_s = push_s && (state_n_s == TRACK);
  assign avg_s        = sum_r[SUM_W-1:2];

  // Timebase prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + DIV_W'(1);
    end
  end

  // Interval counter; an accepted beat wins over a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (cnt_clr_s) begin
      cnt_r <= '0;
    end else if (tick_s && (cnt_r != TIMEOUT_C)) begin
      cnt_r <= cnt_r + PERIOD_W'(1);
    end
  end

  // FSM state and fill-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      fill_r  <= 3'd0;
    end else begin
      state_r <= state_n_s;
      if (clr_s) begin
        fill_r <= 3'd0;
      end else if (push_s && (state_r != TRACK)) begin
        fill_r <= fill_r + 3'd1;
      end
    end
  end

  // Next-state logic: timeout has priority, artifacts below MIN_PERIOD are ignored.
  always_comb begin
    state_n_s = state_r;
    push_s    = 1'b0;
    clr_s     = 1'b0;
    cnt_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (beat_evt_s) begin
          cnt_clr_s = 1'b1;
          state_n_s = ARMED;
        end else begin
          state_n_s = IDLE;
        end
      end
      ARMED, FILL, TRACK: begin
        if (timeout_s) begin
          clr_s     = 1'b1;
          cnt_clr_s = beat_evt_s;
          state_n_s = beat_evt_s ? ARMED : IDLE;
        end else if (beat_evt_s && (cnt_r >= MIN_C)) begin
          push_s    = 1'b1;
          cnt_clr_s = 1'b1;
          if (state_r == ARMED) begin
            state_n_s = FILL;
          end else if ((state_r == FILL) && (fill_r == 3'(AVG_DEPTH - 1))) begin
            state_n_s = TRACK;
          end else begin
            state_n_s = state_r;
          end
        end else begin
          state_n_s = state_r;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Interval shift buffer with running sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AVG_DEPTH; i++) buf_r[i] <= '0;
      sum_r <= '0;
    end else if (clr_s) begin
      for (int i = 0; i < AVG_DEPTH; i++) buf_r[i] <= '0;
      sum_r <= '0;
    end else if (push_s) begin
      buf_r[0] <= cnt_r;
      for (int i = 1; i < AVG_DEPTH; i++) buf_r[i] <= buf_r[i-1];
      sum_r <= sum_r - {2'b00, buf_r[AVG_DEPTH-1]} + {2'b00, cnt_r};
    end
  end

  // Second pipeline stage: average, classification and output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_pend_r   <= 1'b0;
      trk_pend_r   <= 1'b0;
      status       <= STATUS_NONE;
      status_valid <= 1'b0;
      status_upd   <= 1'b0;
      avg_period   <= '0;
      lost         <= 1'b0;
    end else begin
      upd_pend_r <= push_s;
      trk_pend_r <= track_push_s;
      lost       <= clr_s;
      status_upd <= 1'b0;
      if (clr_s) begin
        status       <= STATUS_NONE;
        status_valid <= 1'b0;
        avg_period   <= '0;
      end else if (upd_pend_r) begin
        avg_period <= avg_s;
        if (trk_pend_r) begin
          status       <= classify(16'(avg_s));
          status_valid <= 1'b1;
          status_upd   <= 1'b1;
        end
      end
    end
  end

endmodule
